nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle add/subtract unit that computes a WIDTH-bit sum or difference by sequencing a single 4-bit carry-lookahead slice (the existing `cla_4bit` block) over WIDTH/4 consecutive cycles. A registered carry links the nibbles, least-significant first. The block sits between a requester using a start/done handshake and the shared 4-bit adder datapath. It trades latency for area wherever a full-width adder is not justified.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8. N = WIDTH/4 nibble steps.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk; accepted only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a−b; sampled with an accepted start.
- a  input  WIDTH  operand A; sampled with an accepted start.
- b  input  WIDTH  operand B; sampled with an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result, cout and ovf are valid from this cycle on.
- result  output  WIDTH  sum or difference; holds until the next done.
- cout  output  1  carry out of bit WIDTH−1; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE, start=0: stay in IDLE.
- IDLE or DONE, start=1, on the accepting edge:
  - a_reg <= a.
  - b_reg <= sub ? ~b : b.
  - carry <= sub.
  - cnt <= 0.
  - Capture a[WIDTH−1] and the effective b MSB for overflow.
  - Next state: RUN.
- DONE, start=0: next state IDLE.
- RUN, each cycle:
  - Slice inputs: a_reg[3:0], b_reg[3:0], cin = carry.
  - acc <= {slice_sum, acc[WIDTH−1:4]}.
  - a_reg and b_reg shift right by 4.
  - carry <= slice_cout.
  - cnt increments.
  - On the edge where cnt = N−1: next state DONE; result <= final acc value; cout <= slice_cout; ovf <= (a_msb == beff_msb) && (sum_msb != a_msb).
- start during RUN is ignored and has no side effects. Inputs a, b and sub may change freely after acceptance.
- cnt width is clog2(N). It never wraps past N−1 inside a run.
- Only one adder slice is instantiated. No full-width adder is inferred.

## Timing
- Reset values, asynchronous: busy=0, done=0, result=0, cout=0, ovf=0. State IDLE; carry, cnt, acc, a_reg and b_reg all 0.
- Start accepted at edge k:
  - busy is high for cycles k+1 through k+N.
  - done is high for exactly cycle k+N+1.
  - Latency from the accepting edge to done is N+1 edges (16-bit: 5).
- result, cout and ovf change only on the edge that raises done, then hold stable.
- Back-to-back: a start sampled during the done cycle is accepted. busy rises on the next cycle and done deasserts. Throughput is one operation per N+1 cycles.
- rst_n low mid-RUN: the operation aborts immediately. All outputs go to their reset values and no done is produced. The first start after rst_n deasserts is handled normally.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Add, WIDTH=16: a=0x1234, b=0x4321, sub=0 -> done 5 cycles after acceptance; result=0x5555, cout=0, ovf=0; busy high exactly 4 cycles.
- Carry ripple across all nibbles: a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, cout=1, ovf=0.
- Signed overflow:
  - a=0x7FFF + b=0x0001 -> result=0x8000, cout=0, ovf=1.
  - a=0x8000 − b=0x0001 (sub=1) -> result=0x7FFF, cout=1, ovf=1.
  - a=0x0005 − b=0x0007 -> result=0xFFFE, cout=0, ovf=0.
- start ignored in RUN: start pulse at 0x1111+0x2222, second start with different operands 2 cycles later -> only one done; result=0x3333; previous result held until that done.
- Back-to-back, then reset:
  - Second start during the done cycle -> busy reasserts the next cycle; second result correct.
  - Then rst_n low during RUN cycle 2 -> outputs 0, no done.
  - New start after reset completes correctly.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract built from one 4-bit
// carry-lookahead slice that is stepped over WIDTH/4 cycles, LSB nibble first.
// Handshake: a start sampled high while the block is in IDLE or DONE is
// accepted on that rising edge. busy is high for the N RUN cycles that follow.
// done then pulses for one cycle. result/cout/ovf update only on the edge
// that raises done, and hold until the next done.

// 4-bit carry-lookahead adder slice.
module cla_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and lookahead carries.
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = c_i;
        c[1] = g[0] | (p[0] & c_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_i);
        s_o  = p ^ c[3:0];
        c_o  = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);
    localparam int N     = WIDTH / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             beff_msb_q, beff_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       slice_sum;
    logic             slice_cout;

    // The one and only adder slice; fed from the low nibble of the shifters.
    cla_4bit u_slice (
        .a_i (a_q[3:0]),
        .b_i (b_q[3:0]),
        .c_i (carry_q),
        .s_o (slice_sum),
        .c_o (slice_cout)
    );

    // Next-state and datapath update; every _d defaults to hold.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        a_msb_d    = a_msb_q;
        beff_msb_d = beff_msb_q;
        result_d   = result_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry.
                    a_d        = a;
                    b_d        = sub ? ~b : b;
                    carry_d    = sub;
                    cnt_d      = '0;
                    a_msb_d    = a[WIDTH-1];
                    beff_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    state_d    = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = {slice_sum, acc_q[WIDTH-1:4]};
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = slice_cout;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    result_d = {slice_sum, acc_q[WIDTH-1:4]};
                    cout_d   = slice_cout;
                    ovf_d    = (a_msb_q == beff_msb_q) && (slice_sum[3] != a_msb_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            a_msb_q    <= 1'b0;
            beff_msb_q <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            a_msb_q    <= a_msb_d;
            beff_msb_q <= beff_msb_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    // Outputs come straight from registers or a decode of the state register.
    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        result    = result_q;
        cout      = cout_q;
        ovf       = ovf_q;
        dbg_state = state_q;
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed cases, start-ignored, back-to-back,
// mid-run reset and randomized operations against an arithmetic model.
module tb_nibble_serial_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    // Expected {ovf, cout, result} per accepted operation.
    logic [W+1:0] exp_q[$];

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled on the falling edge.
    always @(negedge clk) if (done) done_cnt = done_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms);
        longint ua, ub, full, sa, sb, sr, mod;
        logic   r_c, r_o;
        logic [W-1:0] r;
        mod  = longint'(1) << W;
        ua   = longint'(ma);
        ub   = longint'(mb);
        full = ms ? (ua - ub + mod) : (ua + ub);
        r    = W'(full % mod);
        r_c  = (full >= mod);
        sa   = ma[W-1] ? ua - mod : ua;
        sb   = mb[W-1] ? ub - mod : ub;
        sr   = ms ? sa - sb : sa + sb;
        r_o  = (sr > (mod / 2) - 1) || (sr < -(mod / 2));
        return {r_o, r_c, r};
    endfunction

    // Must be called at a falling edge; start is accepted on the next rising edge.
    // Returns at a falling edge after the done pulse plus 'gap' idle cycles.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          input int gap);
        logic [W-1:0] prev_res;
        logic [W+1:0] e;
        int           lat, busy_cnt;
        bit           seen, held;
        prev_res = result;
        exp_q.push_back(model(ta, tb_v, ts));
        start = 1'b1; a = ta; b = tb_v; sub = ts;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        lat = 1; busy_cnt = 0; seen = 0; held = 1;
        while (!seen && lat <= 20) begin
            if (done) seen = 1;
            else begin
                if (busy) busy_cnt++;
                if (result !== prev_res) held = 0;
                lat++;
                @(negedge clk);
            end
        end
        e = exp_q.pop_front();
        if (!seen) begin
            check_eq("done_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("latency", lat, N + 1);
            check_eq("busy_cycles", busy_cnt, N);
            check_eq("hold_prev", {31'd0, held}, 32'd1);
            check_eq("busy_at_done", {31'd0, busy}, 32'd0);
            check_eq("result", {16'd0, result}, {16'd0, e[W-1:0]});
            check_eq("cout", {31'd0, cout}, {31'd0, e[W]});
            check_eq("ovf", {31'd0, ovf}, {31'd0, e[W+1]});
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check_eq("done_pulse", {31'd0, done}, 32'd0);
            check_eq("result_hold", {16'd0, result}, {16'd0, e[W-1:0]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_result"}, {16'd0, result}, 32'd0);
        check_eq({tag, "_cout"}, {31'd0, cout}, 32'd0);
        check_eq({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    logic [W-1:0] dir_a [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000};
    logic [W-1:0] dir_b [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h8000};
    logic         dir_s [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int dc0;
        logic [W-1:0] prev;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        for (int i = 0; i < 6; i++) run_op(dir_a[i], dir_b[i], dir_s[i], 1);

        // A start during RUN is ignored.
        prev = result;
        dc0  = done_cnt;
        start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
        @(negedge clk); start = 1'b0;
        check_eq("ign_busy", {31'd0, busy}, 32'd1);
        check_eq("ign_hold", {16'd0, result}, {16'd0, prev});
        repeat (10) @(negedge clk);
        #1;
        check_eq("ign_one_done", done_cnt - dc0, 32'd1);
        check_eq("ign_result", {16'd0, result}, 32'h3333);
        check_eq("ign_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);

        // Back-to-back: second start lands in the done cycle.
        run_op(16'hABCD, 16'h1357, 1'b0, 0);
        run_op(16'h1000, 16'h2001, 1'b1, 1);

        // Reset during RUN cycle 2 aborts the operation.
        start = 1'b1; a = 16'h0F0F; b = 16'h0101; sub = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        dc0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check_eq("abort_no_done", done_cnt - dc0, 32'd0);
        @(negedge clk);
        run_op(16'h0F0F, 16'h0101, 1'b0, 1);

        // Randomized operations with random gaps (0 = back-to-back).
        for (int i = 0; i < 40; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2));
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
